// File: rtl/pixel_shifter.sv
// Video byte to pixel serializer; optional PIXEL_DOUBLE_EN holds each pixel for two enable slots.
// Latency: pixel is registered one cycle after the enable edge that selects it.
// Backpressure: data_ready = !hold_full; a data_valid offered while the hold buffer is full is ignored.
module pixel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [1:0]       pixel,
    output logic             pixel_valid,
    output logic             underrun
);

    localparam int RW = $clog2(WIDTH + 1);
    localparam logic [RW-1:0] WIDTH_R = RW'(WIDTH);

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [RW-1:0]    rem;
    logic             mode_q;

    logic             take;
    logic             slot;
    logic             repeat_slot;
    logic [RW-1:0]    step_cur;
    logic [RW-1:0]    step_new;
    logic             load;

    assign data_ready = !hold_full;
    assign take       = data_valid && data_ready;

    // step for the byte in flight uses its latched mode; a byte being loaded uses the live mode
    assign step_cur = mode_q ? RW'(2) : RW'(1);
    assign step_new = mode   ? RW'(2) : RW'(1);

`ifdef PIXEL_DOUBLE_EN
    logic phase;

    // phase 0 makes the shift/load/underrun decision, phase 1 repeats the pixel
    assign slot        = enable && !phase;
    assign repeat_slot = enable && phase;

    // phase toggles on every enable slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (enable) begin
            phase <= !phase;
        end
    end
`else
    assign slot        = enable;
    assign repeat_slot = 1'b0;
`endif

    assign load = slot && (rem == '0) && hold_full;

    // holding buffer: fill on handshake, empty when its byte moves into the shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (take) begin
            hold      <= data_in;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // shift register, remaining-bit count and registered pixel outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            rem         <= '0;
            mode_q      <= 1'b0;
            pixel       <= 2'b00;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (slot) begin
                if (rem != '0) begin
                    pixel       <= mode_q ? shreg[WIDTH-1:WIDTH-2] : {2{shreg[WIDTH-1]}};
                    pixel_valid <= 1'b1;
                    shreg       <= shreg << step_cur;
                    rem         <= rem - step_cur;
                end else if (hold_full) begin
                    pixel       <= mode ? hold[WIDTH-1:WIDTH-2] : {2{hold[WIDTH-1]}};
                    pixel_valid <= 1'b1;
                    shreg       <= hold << step_new;
                    rem         <= WIDTH_R - step_new;
                    mode_q      <= mode;
                end else begin
                    pixel       <= 2'b00;
                    pixel_valid <= 1'b0;
                    underrun    <= 1'b1;
                end
            end else if (repeat_slot) begin
                pixel       <= pixel;
                pixel_valid <= pixel_valid;
            end
        end
    end

endmodule

// File: doc/pixel_shifter.md
PIXEL_SHIFTER -- requirements
Module: pixel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per video data byte; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  pixel-advance strobe, one pixel slot per high clk cycle.
REQ-005 SHALL have port mode  input  1  0 = 1 bit per pixel, 1 = 2 bits per pixel.
REQ-006 SHALL have port data_in  input  WIDTH  video byte from the address/fetch side.
REQ-007 SHALL have port data_valid  input  1  data_in holds a byte offered for transfer.
REQ-008 SHALL have port data_ready  output  1  shifter can accept a byte this cycle.
REQ-009 SHALL have port pixel  output  2  current pixel code.
REQ-010 SHALL have port pixel_valid  output  1  pixel carries real data, not underrun fill.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse: a slot occurred with no data available.

Function
REQ-012 SHALL hold state in two parts: a one-entry holding buffer (hold, hold_full) and a shift register (shreg) with a remaining-bit count (rem, 0..WIDTH).
REQ-013 SHALL drive data_ready = !hold_full combinationally from registered state.
REQ-014 SHALL transfer data_in into hold on a rising edge where data_valid && data_ready; data_valid while not ready SHALL be ignored, with no loss of hold.
REQ-015 SHALL latch mode into a per-byte mode register when a byte moves from hold to shreg; mode changes mid-byte SHALL take effect only at the next byte.
REQ-016 SHALL define step = 1 (latched mode 0) or 2 (latched mode 1).
REQ-017 SHALL, on an enable cycle with rem > 0, register pixel = {msb,msb} (mode 0) or the top two bits (mode 1), set pixel_valid=1, shift shreg left by step, and reduce rem by step.
REQ-018 SHALL, on an enable cycle with rem == 0 and hold_full, load hold into shreg, emit its first pixel in the same cycle as REQ-017, set rem = WIDTH-step, and clear hold_full.
REQ-019 SHALL, when REQ-018 coincides with a data_valid && data_ready transfer, refill hold with no bubble; hold_full ends the cycle set.
REQ-020 SHALL, on an enable cycle with rem == 0 and !hold_full, set pixel=2'b00, pixel_valid=0, and underrun=1 for exactly that cycle.
REQ-021 SHALL keep pixel and pixel_valid unchanged on cycles with enable low; underrun SHALL be 0 on any non-underrun cycle.
REQ-022 SHALL produce pixel one cycle after the enable edge that selects it (registered output, latency 1).
REQ-023 SHALL sustain WIDTH (mode 0) or WIDTH/2 (mode 1) consecutive valid pixels per byte, with back-to-back bytes gapless when hold is refilled before rem reaches 0.

Reset
REQ-024 SHALL, while reset is high, asynchronously force hold_full=0, rem=0, shreg=0, hold=0, latched mode=0, pixel=2'b00, pixel_valid=0, underrun=0; data_ready therefore reads 1.
REQ-025 SHALL discard any partially shifted byte and any held byte on reset mid-operation; the first enable after release with no data SHALL signal underrun.

Configuration
REQ-026 SHALL provide macro PIXEL_DOUBLE_EN: when defined, each pixel is held for two consecutive enable slots via an internal phase bit cleared by reset; shift, load and underrun decisions occur only on phase 0, and phase 1 repeats pixel/pixel_valid with underrun=0.
REQ-027 SHALL, without PIXEL_DOUBLE_EN, advance one pixel per enable slot with no phase bit present in the design.

Verification
REQ-028 Reset, then enable held high with data_valid=0 -> pixel=00, pixel_valid=0, underrun=1 on every enable cycle, data_ready=1.
REQ-029 mode=0, load 8'hA5, enable continuous -> pixel sequence 11,00,11,00,00,11,00,11, pixel_valid=1 for 8 cycles, then underrun.
REQ-030 mode=1, load 8'h1B then 8'hE4 offered immediately -> pixels 00,01,10,11,11,10,01,00 gapless; data_ready low while hold is full.
REQ-031 Reset asserted after 3 pixels of 8'hFF with hold full -> outputs zero immediately, hold and shreg are discarded, and the next enable gives underrun.
REQ-032 With PIXEL_DOUBLE_EN, mode=0, load 8'h80 -> pixel 11,11 then 00 for 14 slots, a total of 16 valid slots.
